// File: rtl/fifo_wr_pkg.sv
// Shared defaults and occupancy encoding for the async-FIFO write-side adapter.
package fifo_wr_pkg;
    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_wr_adapter_skid_buf2.sv
// Two-entry in-order skid buffer; entry 0 is always the head presented downstream.
module skid_buf2
    import fifo_wr_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_last,
    output logic [DSIZE-1:0] head_data,
    output logic             head_last,
    output state_t           state
);
    state_t           state_nxt;
    logic [DSIZE-1:0] data0, data1;
    logic             last0, last1;
    logic             ld0_in, ld0_shift, ld1;
    logic             do_push, do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush;

    always_comb begin
        state_nxt = state;
        ld0_in    = 1'b0;
        ld0_shift = 1'b0;
        ld1       = 1'b0;
        case (state)
            EMPTY: if (do_push) begin
                state_nxt = ONE;
                ld0_in    = 1'b1;
            end
            ONE: begin
                if (do_push && do_pop) begin
                    ld0_in = 1'b1;
                end else if (do_push) begin
                    state_nxt = TWO;
                    ld1       = 1'b1;
                end else if (do_pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: if (do_pop) begin
                state_nxt = ONE;
                ld0_shift = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) state <= EMPTY;
        else         state <= state_nxt;
    end

    // Entry 0 is left untouched on a plain pop so it keeps the last written word.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            data0 <= '0;
            last0 <= 1'b0;
            data1 <= '0;
            last1 <= 1'b0;
        end else begin
            if (ld0_in) begin
                data0 <= in_data;
                last0 <= in_last;
            end else if (ld0_shift) begin
                data0 <= data1;
                last0 <= last1;
            end
            if (ld1) begin
                data1 <= in_data;
                last1 <= in_last;
            end
        end
    end

    assign head_data = data0;
    assign head_last = last0;
endmodule

// File: rtl/fifo_wr_adapter.sv
// Write-side adapter from a valid/ready stream into an async FIFO, with word and frame counters.
module fifo_wr_adapter
    import fifo_wr_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_last,
    input  logic             flush,
    input  logic             wfull,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy
);
    state_t state;
    logic   head_last;
    logic   push;

    assign s_ready = (state != TWO) & ~flush;
    assign push    = s_valid & s_ready;
    assign winc    = (state != EMPTY) & ~wfull & ~flush;
    assign busy    = (state != EMPTY);

    skid_buf2 #(.DSIZE(DSIZE)) u_buf (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .push      (push),
        .pop       (winc),
        .flush     (flush),
        .in_data   (s_data),
        .in_last   (s_last),
        .head_data (wdata),
        .head_last (head_last),
        .state     (state)
    );

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_count    <= '0;
            frame_count <= '0;
        end else if (winc) begin
            wr_count <= wr_count + CNT_W'(1);
            if (head_last) frame_count <= frame_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Self-checking bench for fifo_wr_adapter: scoreboard on winc/wdata plus table and hand sequences.
module tb_fifo_wr_adapter;
    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        flush = 1'b0;
    logic        wfull = 1'b0;
    logic        s_ready, winc, busy;
    logic [7:0]  wdata;
    logic [15:0] wr_count, frame_count;
    logic        s_ready4, winc4, busy4;
    logic [7:0]  wdata4;
    logic [3:0]  wr_count4, frame_count4;

    int total = 0;
    int bad   = 0;

    always #5 wclk = ~wclk;

    fifo_wr_adapter #(.DSIZE(8), .CNT_W(16)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .flush(flush), .wfull(wfull),
        .winc(winc), .wdata(wdata), .wr_count(wr_count),
        .frame_count(frame_count), .busy(busy)
    );

    fifo_wr_adapter #(.DSIZE(8), .CNT_W(4)) dut4 (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready4),
        .s_data(s_data), .s_last(s_last), .flush(flush), .wfull(wfull),
        .winc(winc4), .wdata(wdata4), .wr_count(wr_count4),
        .frame_count(frame_count4), .busy(busy4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: words accepted upstream are queued, and each winc must present the oldest one.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } sb_t;
    sb_t         sb[$];
    logic [15:0] m_wr = '0;
    logic [15:0] m_fr = '0;

    always @(negedge wclk) begin
        if (!wrst_n) begin
            sb.delete();
            m_wr = '0;
            m_fr = '0;
        end else begin
            chk("sb_wr_count", 32'(wr_count), 32'(m_wr));
            chk("sb_frame_count", 32'(frame_count), 32'(m_fr));
            if (flush) begin
                chk("sb_flush_winc", 32'(winc), 32'd0);
                sb.delete();
            end else begin
                if (winc) begin
                    if (sb.size() == 0) begin
                        chk("sb_winc_no_word", 32'(winc), 32'd0);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        chk("sb_wdata", 32'(wdata), 32'(e.data));
                        m_wr = m_wr + 16'd1;
                        if (e.last) m_fr = m_fr + 16'd1;
                    end
                end
                if (s_valid && s_ready) sb.push_back({s_data, s_last});
            end
        end
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       wf;
        logic       fl;
        logic       rdy;
        logic       wi;
        logic       bz;
        logic [7:0] wd;
    } vec_t;
    vec_t tbl[13];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic wf, input logic fl, input logic rdy,
                                input logic wi, input logic bz, input logic [7:0] wd);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.wf = wf; r.fl = fl;
        r.rdy = rdy; r.wi = wi; r.bz = bz; r.wd = wd;
        return r;
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        flush   = 1'b0;
        wfull   = 1'b0;
        wrst_n  = 1'b0;
        step();
        step();
        wrst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_one(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] wrap_exp[3];
        int         npulse;

        // Backpressure then flush, one row per cycle; outputs checked mid-cycle.
        tbl[0]  = mk(1, 8'hA1, 0, 1, 0, 1, 0, 0, 8'h00);
        tbl[1]  = mk(1, 8'hA2, 0, 1, 0, 1, 0, 1, 8'h00);
        tbl[2]  = mk(1, 8'hA3, 1, 1, 0, 0, 0, 1, 8'h00);
        tbl[3]  = mk(1, 8'hA3, 1, 0, 0, 0, 1, 1, 8'hA1);
        tbl[4]  = mk(1, 8'hA3, 1, 0, 0, 1, 1, 1, 8'hA2);
        tbl[5]  = mk(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'hA3);
        tbl[6]  = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00);
        tbl[7]  = mk(1, 8'hB1, 0, 1, 0, 1, 0, 0, 8'h00);
        tbl[8]  = mk(1, 8'hB2, 0, 1, 0, 1, 0, 1, 8'h00);
        tbl[9]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h00);
        tbl[10] = mk(1, 8'h77, 1, 0, 0, 1, 0, 0, 8'h00);
        tbl[11] = mk(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'h77);
        tbl[12] = mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00);
        wrap_exp[0] = 4'd15;
        wrap_exp[1] = 4'd0;
        wrap_exp[2] = 4'd1;

        // Reset values, asynchronous and before any clock edge.
        #2;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        step();
        wrst_n = 1'b1;

        // Single word, one-cycle latency.
        send_one(8'h5A, 1'b1);
        @(negedge wclk);
        chk("single_winc", 32'(winc), 32'd1);
        chk("single_wdata", 32'(wdata), 32'h5A);
        step();
        chk("single_wr_count", 32'(wr_count), 32'd1);
        chk("single_frame_count", 32'(frame_count), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);
        chk("single_wdata_hold", 32'(wdata), 32'h5A);

        // Streaming 16 words with no bubbles.
        do_reset();
        npulse  = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 8'(i + 1);
            s_last = (i == 15);
            @(negedge wclk);
            if (i > 0) chk("stream_winc", 32'(winc), 32'd1);
            if (winc) npulse++;
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge wclk);
        chk("stream_tail_winc", 32'(winc), 32'd1);
        if (winc) npulse++;
        step();
        drain();
        chk("stream_pulses", 32'(npulse), 32'd16);
        chk("stream_wr_count", 32'(wr_count), 32'd16);
        chk("stream_frame_count", 32'(frame_count), 32'd1);

        // Table: backpressure, flush, recovery.
        do_reset();
        foreach (tbl[k]) begin
            s_valid = tbl[k].v;
            s_data  = tbl[k].d;
            s_last  = tbl[k].l;
            wfull   = tbl[k].wf;
            flush   = tbl[k].fl;
            @(negedge wclk);
            chk($sformatf("tbl%0d_s_ready", k), 32'(s_ready), 32'(tbl[k].rdy));
            chk($sformatf("tbl%0d_winc", k), 32'(winc), 32'(tbl[k].wi));
            chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].bz));
            if (tbl[k].wi) chk($sformatf("tbl%0d_wdata", k), 32'(wdata), 32'(tbl[k].wd));
            step();
        end
        s_valid = 1'b0;
        flush   = 1'b0;
        wfull   = 1'b0;
        chk("tbl_wr_count", 32'(wr_count), 32'd4);
        chk("tbl_frame_count", 32'(frame_count), 32'd2);

        // Reset asserted mid-burst with two words buffered.
        wfull = 1'b1;
        send_one(8'hC1, 1'b0);
        send_one(8'hC2, 1'b1);
        @(negedge wclk);
        chk("mid_busy_two", 32'(busy), 32'd1);
        chk("mid_s_ready_two", 32'(s_ready), 32'd0);
        step();
        wfull  = 1'b0;
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_winc", 32'(winc), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
        chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
        chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
        step();
        wrst_n = 1'b1;
        repeat (4) begin
            @(negedge wclk);
            chk("mid_post_winc", 32'(winc), 32'd0);
        end
        step();

        // Counter wrap on the CNT_W=4 instance.
        do_reset();
        s_valid = 1'b1;
        s_last  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            s_data = 8'(8'h20 + i);
            step();
        end
        s_valid = 1'b0;
        drain();
        step();
        chk("wrap_pre_count", 32'(wr_count4), 32'd14);
        for (int i = 0; i < 3; i++) begin
            send_one(8'(8'h40 + i), 1'b1);
            step();
            chk($sformatf("wrap_count%0d", i), 32'(wr_count4), 32'(wrap_exp[i]));
        end
        chk("wrap_frame_count", 32'(frame_count4), 32'd3);

        repeat (2) step();
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_adapter.md
FIFO_WR_ADAPTER -- requirements
Module: fifo_wr_adapter

Interface
REQ-001 Parameter DSIZE, default 8, data width; equals the async FIFO DSIZE.
REQ-002 Parameter CNT_W, default 16, width of statistics counters.
REQ-003 wclk  input  1  write-domain clock; all logic on rising edge.
REQ-004 wrst_n  input  1  reset; asynchronous, active-low.
REQ-005 s_valid  input  1  upstream word valid.
REQ-006 s_ready  output  1  adapter can accept a word this cycle.
REQ-007 s_data  input  DSIZE  upstream word.
REQ-008 s_last  input  1  word is last of a frame.
REQ-009 flush  input  1  synchronous discard of buffered words.
REQ-010 wfull  input  1  FIFO full flag, registered in wclk domain.
REQ-011 winc  output  1  FIFO write strobe.
REQ-012 wdata  output  DSIZE  FIFO write data.
REQ-013 wr_count  output  CNT_W  words written to FIFO.
REQ-014 frame_count  output  CNT_W  frames (last-flagged words) written to FIFO.
REQ-015 busy  output  1  buffer non-empty.

Function
REQ-016 The block SHALL hold a 2-entry in-order skid buffer, each entry {data, last}, and track occupancy as FSM states EMPTY, ONE, TWO.
REQ-017 Push SHALL occur when s_valid & s_ready; pop SHALL occur when winc=1.
REQ-018 s_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, and 0 whenever flush=1.
REQ-019 winc SHALL equal (state!=EMPTY) & ~wfull & ~flush, combinationally.
REQ-020 wdata SHALL always present head-entry data; when EMPTY it SHALL hold the last popped value (0 after reset).
REQ-021 Transitions: EMPTY-push->ONE; ONE-push-only->TWO; ONE-pop-only->EMPTY; ONE-push&pop->ONE (new word becomes head); TWO-pop->ONE; otherwise hold.
REQ-022 Minimum latency SHALL be one cycle: word pushed at edge N drives winc/wdata during cycle N+1 if wfull=0.
REQ-023 No bubble: with s_valid held high and wfull=0, winc SHALL be 1 every cycle from the second cycle onward.
REQ-024 While wfull=1 no word SHALL be popped or lost; words remain in order until wfull falls.
REQ-025 wr_count SHALL increment by 1 on every winc, wrapping from 2^CNT_W-1 to 0.
REQ-026 frame_count SHALL increment by 1 on every winc whose head entry has last=1, wrapping identically.
REQ-027 flush=1 SHALL move state to EMPTY at the next edge, suppress push and pop that cycle, and leave counters unchanged.
REQ-028 busy SHALL equal (state!=EMPTY).

Reset
REQ-029 On wrst_n=0, state SHALL be EMPTY, entries and wdata 0, wr_count and frame_count 0, immediately and independent of wclk.
REQ-030 During reset s_ready SHALL be 1, winc 0, busy 0; reset mid-burst SHALL discard buffered words with no winc pulse.
REQ-031 Release of wrst_n SHALL be treated as synchronous to wclk; first push possible on the first edge after release.

Structure
REQ-032 Shared package fifo_wr_pkg SHALL hold the DSIZE and CNT_W defaults and the state encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
REQ-033 The buffer and FSM SHALL be one sub-module skid_buf2; counters and winc logic stay in fifo_wr_adapter.

Verification
REQ-034 Single word: s_data=8'h5A, s_last=1, one cycle after reset, wfull=0 -> winc=1 next cycle with wdata=8'h5A; wr_count=1, frame_count=1.
REQ-035 Streaming: 16 back-to-back words 8'h01..8'h10, last on 8'h10, wfull=0 -> 16 consecutive winc pulses in order; wr_count=16, frame_count=1.
REQ-036 Backpressure: wfull=1 while sending 8'hA1,8'hA2,8'hA3 -> s_ready=0 after two pushes, winc=0; drop wfull -> A1,A2,A3 written in order, none lost.
REQ-037 Flush: buffer holds 2 words, assert flush one cycle -> state EMPTY, no winc, counters unchanged, next word 8'h77 written normally.
REQ-038 Wrap: preload counters near 2^CNT_W-1 (CNT_W=4), write 3 words -> wr_count 15 then 0 then 1.
REQ-039 Reset mid-burst: wrst_n low with TWO occupied -> winc=0, busy=0, counters 0 immediately, no stale word written after release.
